uart_frame_scheduler: RTL

//  Host-command front end for the 16-channel sampler link. Parses UART_RX bytes into
//  5-byte command packets, holds the channel-enable mask and frame period, and sequences

---
 rtl/uart_frame_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_frame_scheduler.sv
// Host-command front end for the sampler link: parses 5-byte UART packets, holds the
// channel mask and frame period, and paces FRAME_REQ strobes with overrun accounting.
module uart_frame_scheduler #(
  parameter int unsigned PRESCALE   = 50,
  parameter int unsigned TIMEOUT    = 500000,
  parameter logic [15:0] DEF_MASK   = 16'hFFFF,
  parameter logic [15:0] DEF_PERIOD = 16'd1000
) (
  input  logic        CLK_50M,
  input  logic        RESET_n,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  input  logic        FRAME_BUSY,
  output logic        FRAME_REQ,
  output logic [15:0] CH_MASK,
  output logic        STREAM_ON,
  output logic        CMD_ERR,
  output logic [7:0]  OVR_CNT
);

  localparam int unsigned PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [19:0]   TO_LAST = 20'(TIMEOUT - 1);

  typedef enum logic [2:0] {P_IDLE, P_CMD, P_AH, P_AL, P_CHK} pstate_t;

  pstate_t        st_q, st_d;
  logic [7:0]     cmd_q, cmd_d, ah_q, ah_d, al_q, al_d;
  logic [19:0]    to_q, to_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [15:0]    per_cnt_q, per_cnt_d;
  logic [15:0]    period_q, period_d;
  logic [15:0]    mask_q, mask_d;
  logic           stream_q, stream_d;
  logic           pend_q, pend_d;
  logic           req_q, req_d;
  logic           err_q, err_d;
  logic [7:0]     ovr_q, ovr_d;

  logic           pkt_ok, legacy_shot;
  logic           do_mask, do_per, do_shot, do_start, do_stop;
  logic           tick, per_clr, per_evt, issue, pend_eff;
  logic [15:0]    arg;

  // Packet parser; the byte timeout applies only while a packet is in flight.
  always_comb begin
    st_d        = st_q;
    cmd_d       = cmd_q;
    ah_d        = ah_q;
    al_d        = al_q;
    to_d        = '0;
    pkt_ok      = 1'b0;
    legacy_shot = 1'b0;
    err_d       = 1'b0;
    unique case (st_q)
      P_IDLE: if (RX_VALID) begin
        if (RX_DATA == 8'hA5)      st_d = P_CMD;
        else if (RX_DATA == 8'hFF) legacy_shot = 1'b1;
      end
      P_CMD: if (RX_VALID) begin cmd_d = RX_DATA; st_d = P_AH;  end
      P_AH:  if (RX_VALID) begin ah_d  = RX_DATA; st_d = P_AL;  end
      P_AL:  if (RX_VALID) begin al_d  = RX_DATA; st_d = P_CHK; end
      P_CHK: if (RX_VALID) begin
        st_d = P_IDLE;
        if (RX_DATA == (cmd_q ^ ah_q ^ al_q) && cmd_q >= 8'h01 && cmd_q <= 8'h05)
          pkt_ok = 1'b1;
        else
          err_d = 1'b1;
      end
      default: st_d = P_IDLE;
    endcase
    if (st_q != P_IDLE && !RX_VALID) begin
      if (to_q == TO_LAST) begin
        st_d  = P_IDLE;
        err_d = 1'b1;
      end else begin
        to_d = to_q + 20'd1;
      end
    end
  end

  assign arg      = {ah_q, al_q};
  assign do_mask  = pkt_ok && (cmd_q == 8'h01);
  assign do_per   = pkt_ok && (cmd_q == 8'h02);
  assign do_shot  = (pkt_ok && (cmd_q == 8'h03)) || legacy_shot;
  assign do_start = pkt_ok && (cmd_q == 8'h04);
  assign do_stop  = pkt_ok && (cmd_q == 8'h05);

  assign tick     = (presc_q == P_LAST);
  assign per_clr  = do_per || do_start;
  assign per_evt  = tick && stream_q && (per_cnt_q == period_q - 16'd1) && !per_clr;
  assign issue    = pend_q && !FRAME_BUSY && !req_q;
  // A request being issued this cycle no longer counts as pending for overrun purposes.
  assign pend_eff = pend_q && !issue;

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    per_cnt_d = per_cnt_q;
    period_d  = period_q;
    mask_d    = mask_q;
    stream_d  = stream_q;
    ovr_d     = ovr_q;
    req_d     = issue;
    pend_d    = pend_eff || do_shot || do_start || per_evt;
    if (per_clr)
      per_cnt_d = '0;
    else if (tick && stream_q)
      per_cnt_d = per_evt ? '0 : per_cnt_q + 16'd1;
    if (do_per)   period_d = (arg == 16'd0) ? 16'd1 : arg;
    if (do_mask)  mask_d   = arg;
    if (do_start) stream_d = 1'b1;
    if (do_stop) begin
      stream_d = 1'b0;
      pend_d   = 1'b0;
    end
    if (per_evt && pend_eff && !(do_shot || do_start) && ovr_q != 8'hFF)
      ovr_d = ovr_q + 8'd1;
  end

  always_ff @(posedge CLK_50M) begin
    if (!RESET_n) begin
      st_q      <= P_IDLE;
      cmd_q     <= '0;
      ah_q      <= '0;
      al_q      <= '0;
      to_q      <= '0;
      presc_q   <= '0;
      per_cnt_q <= '0;
      period_q  <= DEF_PERIOD;
      mask_q    <= DEF_MASK;
      stream_q  <= 1'b0;
      pend_q    <= 1'b0;
      req_q     <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= '0;
    end else begin
      st_q      <= st_d;
      cmd_q     <= cmd_d;
      ah_q      <= ah_d;
      al_q      <= al_d;
      to_q      <= to_d;
      presc_q   <= presc_d;
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      mask_q    <= mask_d;
      stream_q  <= stream_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign FRAME_REQ = req_q;
  assign CH_MASK   = mask_q;
  assign STREAM_ON = stream_q;
  assign CMD_ERR   = err_q;
  assign OVR_CNT   = ovr_q;

endmodule
